// File: rtl/cpu_exec_pkg.sv
// cpu_exec_pkg: shared types for the EX/MEM stage (condition codes, branch kinds, flags).
package cpu_exec_pkg;
  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;
  typedef enum logic [1:0] {
    BR_NONE = 2'b00, BR_COND = 2'b01, BR_CBZ = 2'b10, BR_CBNZ = 2'b11
  } br_kind_e;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: ARM condition-code evaluation against an NZCV flag set.
module cond_eval
  import cpu_exec_pkg::*;
(
  input  cond_e i_cond,
  input  nzcv_t i_flags,
  output logic  o_taken
);
  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = i_flags;
  always_comb begin
    o_taken = 1'b1;
    case (i_cond)
      EQ: o_taken = w_z;
      NE: o_taken = !w_z;
      HS: o_taken = w_c;
      LO: o_taken = !w_c;
      MI: o_taken = w_n;
      PL: o_taken = !w_n;
      VS: o_taken = w_v;
      VC: o_taken = !w_v;
      HI: o_taken = w_c & !w_z;
      LS: o_taken = !w_c | w_z;
      GE: o_taken = w_n == w_v;
      LT: o_taken = w_n != w_v;
      GT: o_taken = !w_z & (w_n == w_v);
      LE: o_taken = w_z | (w_n != w_v);
      default: o_taken = 1'b1;
    endcase
  end
endmodule

// File: rtl/exec_mem_stage.sv
// exec_mem_stage: EX/MEM pipeline register, NZCV flag register and EX branch resolution.
// Optional branch perf counters when EXEC_PERF_CNT_EN is defined.
module exec_mem_stage
  import cpu_exec_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_negative,
  input  logic              ex_zero,
  input  logic              ex_overflow,
  input  logic              ex_carry_out,
  input  logic              ex_set_flags,
  input  logic [1:0]        ex_br_kind,
  input  logic [3:0]        ex_cond,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  output logic              ex_br_taken,
  output logic [3:0]        flags_nzcv,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_br_taken
`ifdef EXEC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_br_resolved,
  output logic [CNT_W-1:0]  perf_br_taken
`endif
);
  logic     w_cond_taken;
  logic     w_kind_taken;
  br_kind_e w_kind;
  assign w_kind = br_kind_e'(ex_br_kind);
  cond_eval u_cond_eval (
    .i_cond (cond_e'(ex_cond)),
    .i_flags(nzcv_t'(flags_nzcv)),
    .o_taken(w_cond_taken)
  );
  // CBZ/CBNZ test the ALU zero flag directly since the ALU passes Rt through.
  assign w_kind_taken = (w_kind == BR_COND) ? w_cond_taken :
                        (w_kind == BR_CBZ)  ? ex_zero :
                        (w_kind == BR_CBNZ) ? !ex_zero : 1'b0;
  assign ex_br_taken = ex_valid & !flush & w_kind_taken;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_nzcv     <= 4'b0000;
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_br_taken   <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        mem_valid     <= 1'b0;
        mem_reg_write <= 1'b0;
        mem_mem_read  <= 1'b0;
        mem_mem_write <= 1'b0;
        mem_br_taken  <= 1'b0;
      end else begin
        mem_valid      <= ex_valid;
        mem_result     <= ex_result;
        mem_store_data <= ex_store_data;
        mem_rd         <= ex_rd;
        mem_reg_write  <= ex_reg_write;
        mem_mem_read   <= ex_mem_read;
        mem_mem_write  <= ex_mem_write;
        mem_br_taken   <= ex_br_taken;
        if (ex_valid && ex_set_flags)
          flags_nzcv <= {ex_negative, ex_zero, ex_carry_out, ex_overflow};
      end
    end
  end
`ifdef EXEC_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_br_resolved <= '0;
      perf_br_taken    <= '0;
    end else if (!stall && !flush) begin
      if (ex_valid && w_kind != BR_NONE) perf_br_resolved <= perf_br_resolved + 1'b1;
      if (ex_br_taken) perf_br_taken <= perf_br_taken + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_exec_mem_stage.sv
// tb_exec_mem_stage: directed self-checking bench for exec_mem_stage.
module tb_exec_mem_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, flush, ex_valid;
  logic [63:0] ex_result, ex_store_data;
  logic        ex_negative, ex_zero, ex_overflow, ex_carry_out, ex_set_flags;
  logic [1:0]  ex_br_kind;
  logic [3:0]  ex_cond;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_br_taken;
  logic [3:0]  flags_nzcv;
  logic        mem_valid;
  logic [63:0] mem_result, mem_store_data;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_br_taken;
`ifdef EXEC_PERF_CNT_EN
  logic [31:0] perf_br_resolved, perf_br_taken;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  exec_mem_stage dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_negative(ex_negative),
    .ex_zero(ex_zero), .ex_overflow(ex_overflow), .ex_carry_out(ex_carry_out),
    .ex_set_flags(ex_set_flags), .ex_br_kind(ex_br_kind), .ex_cond(ex_cond),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_br_taken(ex_br_taken), .flags_nzcv(flags_nzcv),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_br_taken(mem_br_taken)
`ifdef EXEC_PERF_CNT_EN
    , .perf_br_resolved(perf_br_resolved), .perf_br_taken(perf_br_taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle();
    stall = 0; flush = 0; ex_valid = 0; ex_result = '0; ex_store_data = '0;
    ex_negative = 0; ex_zero = 0; ex_overflow = 0; ex_carry_out = 0; ex_set_flags = 0;
    ex_br_kind = 2'b00; ex_cond = 4'h0; ex_rd = '0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0; idle();
    step(); step();
    n_cmp++; if ({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_br_taken} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl got %b exp 00000", {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_br_taken}); end
    n_cmp++; if ({mem_result, mem_store_data, mem_rd} !== '0) begin
      n_bad++; $display("FAIL reset_data got %h %h %h exp 0", mem_result, mem_store_data, mem_rd); end
    n_cmp++; if (flags_nzcv !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b exp 0000", flags_nzcv); end
    reset_n = 1;
    step();
  endtask

  task automatic test_subs_eq();
    ex_valid = 1; ex_result = 64'd0; ex_zero = 1; ex_carry_out = 1; ex_set_flags = 1;
    ex_rd = 5'd3; ex_reg_write = 1; ex_store_data = 64'h1234;
    step();
    n_cmp++; if (flags_nzcv !== 4'b0110) begin n_bad++; $display("FAIL subs_flags got %b exp 0110", flags_nzcv); end
    n_cmp++; if ({mem_valid, mem_rd, mem_reg_write} !== {1'b1, 5'd3, 1'b1}) begin
      n_bad++; $display("FAIL subs_mem got %b %0d %b exp 1 3 1", mem_valid, mem_rd, mem_reg_write); end
    n_cmp++; if (mem_store_data !== 64'h1234) begin n_bad++; $display("FAIL subs_sdata got %h exp 1234", mem_store_data); end
    idle(); ex_valid = 1; ex_br_kind = 2'b01; ex_cond = 4'h0; #1;
    n_cmp++; if (ex_br_taken !== 1'b1) begin n_bad++; $display("FAIL beq_taken got %b exp 1", ex_br_taken); end
    ex_cond = 4'h1; #1;
    n_cmp++; if (ex_br_taken !== 1'b0) begin n_bad++; $display("FAIL bne_taken got %b exp 0", ex_br_taken); end
    ex_cond = 4'h8; #1;
    n_cmp++; if (ex_br_taken !== 1'b0) begin n_bad++; $display("FAIL bhi_taken got %b exp 0", ex_br_taken); end
    ex_cond = 4'h0;
    step();
    n_cmp++; if (mem_br_taken !== 1'b1) begin n_bad++; $display("FAIL beq_mem got %b exp 1", mem_br_taken); end
  endtask

  task automatic test_cond_lt_ge();
    idle(); ex_valid = 1; ex_negative = 1; ex_result = 64'hFFFF_FFFF_FFFF_FFF0;
    step();
    n_cmp++; if (flags_nzcv !== 4'b0110) begin n_bad++; $display("FAIL add_noflags got %b exp 0110", flags_nzcv); end
    n_cmp++; if (mem_result !== 64'hFFFF_FFFF_FFFF_FFF0) begin n_bad++; $display("FAIL add_result got %h exp fff...f0", mem_result); end
    ex_set_flags = 1; ex_overflow = 1;
    step();
    n_cmp++; if (flags_nzcv !== 4'b1001) begin n_bad++; $display("FAIL subs_nv got %b exp 1001", flags_nzcv); end
    idle(); ex_valid = 1; ex_br_kind = 2'b01; ex_cond = 4'hB; #1;
    n_cmp++; if (ex_br_taken !== 1'b0) begin n_bad++; $display("FAIL blt got %b exp 0", ex_br_taken); end
    ex_cond = 4'hA; #1;
    n_cmp++; if (ex_br_taken !== 1'b1) begin n_bad++; $display("FAIL bge got %b exp 1", ex_br_taken); end
    ex_cond = 4'hC; #1;
    n_cmp++; if (ex_br_taken !== 1'b1) begin n_bad++; $display("FAIL bgt got %b exp 1", ex_br_taken); end
    ex_cond = 4'hD; #1;
    n_cmp++; if (ex_br_taken !== 1'b0) begin n_bad++; $display("FAIL ble got %b exp 0", ex_br_taken); end
    ex_cond = 4'h9; #1;
    n_cmp++; if (ex_br_taken !== 1'b1) begin n_bad++; $display("FAIL bls got %b exp 1", ex_br_taken); end
    ex_valid = 0; #1;
    n_cmp++; if (ex_br_taken !== 1'b0) begin n_bad++; $display("FAIL invalid_br got %b exp 0", ex_br_taken); end
    step();
  endtask

  task automatic test_cbz_cbnz();
    idle(); ex_valid = 1; ex_br_kind = 2'b11; ex_zero = 0; #1;
    n_cmp++; if (ex_br_taken !== 1'b1) begin n_bad++; $display("FAIL cbnz got %b exp 1", ex_br_taken); end
    step();
    n_cmp++; if (mem_br_taken !== 1'b1) begin n_bad++; $display("FAIL cbnz_mem got %b exp 1", mem_br_taken); end
    ex_br_kind = 2'b10; #1;
    n_cmp++; if (ex_br_taken !== 1'b0) begin n_bad++; $display("FAIL cbz got %b exp 0", ex_br_taken); end
    step();
    n_cmp++; if (mem_br_taken !== 1'b0) begin n_bad++; $display("FAIL cbz_mem got %b exp 0", mem_br_taken); end
    ex_zero = 1; #1;
    n_cmp++; if (ex_br_taken !== 1'b1) begin n_bad++; $display("FAIL cbz_z got %b exp 1", ex_br_taken); end
    ex_br_kind = 2'b00; #1;
    n_cmp++; if (ex_br_taken !== 1'b0) begin n_bad++; $display("FAIL nobr got %b exp 0", ex_br_taken); end
    step();
  endtask

  task automatic test_stall();
    idle(); ex_valid = 1; ex_result = 64'hAAAA; ex_rd = 5'd7; ex_reg_write = 1; ex_mem_write = 1;
    ex_store_data = 64'h55;
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      ex_result = 64'h100 + 64'(i); ex_rd = 5'(i); ex_reg_write = 0; ex_mem_write = 0; ex_mem_read = 1;
      ex_set_flags = 1; ex_zero = 1; ex_negative = 0; ex_overflow = 0; ex_br_kind = 2'b10;
      step();
      n_cmp++; if ({mem_valid, mem_result, mem_rd, mem_reg_write, mem_mem_read, mem_mem_write, mem_br_taken} !==
                   {1'b1, 64'hAAAA, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0}) begin
        n_bad++; $display("FAIL stall_hold%0d got %b %h %0d exp 1 aaaa 7", i, mem_valid, mem_result, mem_rd); end
      n_cmp++; if (flags_nzcv !== 4'b1001) begin n_bad++; $display("FAIL stall_flags%0d got %b exp 1001", i, flags_nzcv); end
    end
    flush = 1;
    step();
    n_cmp++; if ({mem_valid, mem_result} !== {1'b1, 64'hAAAA}) begin
      n_bad++; $display("FAIL stall_flush got %b %h exp 1 aaaa", mem_valid, mem_result); end
    n_cmp++; if (flags_nzcv !== 4'b1001) begin n_bad++; $display("FAIL stall_flush_flags got %b exp 1001", flags_nzcv); end
    idle(); step();
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL unstall got %b exp 0", mem_valid); end
  endtask

  task automatic test_flush();
    idle(); ex_valid = 1; ex_set_flags = 1; ex_zero = 1; ex_reg_write = 1; ex_mem_read = 1;
    ex_br_kind = 2'b10; flush = 1; #1;
    n_cmp++; if (ex_br_taken !== 1'b0) begin n_bad++; $display("FAIL flush_br got %b exp 0", ex_br_taken); end
    step();
    n_cmp++; if ({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_br_taken} !== 5'b0) begin
      n_bad++; $display("FAIL flush_ctrl got %b exp 00000", {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_br_taken}); end
    n_cmp++; if (flags_nzcv !== 4'b1001) begin n_bad++; $display("FAIL flush_flags got %b exp 1001", flags_nzcv); end
    idle();
  endtask

  task automatic test_back_to_back();
    idle(); ex_valid = 1; ex_result = 64'h11; ex_rd = 5'd1; ex_reg_write = 1;
    step();
    ex_result = 64'h22; ex_rd = 5'd2; ex_reg_write = 0; ex_mem_read = 1;
    n_cmp++; if ({mem_result, mem_rd, mem_reg_write, mem_mem_read} !== {64'h11, 5'd1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL b2b_first got %h %0d exp 11 1", mem_result, mem_rd); end
    step();
    n_cmp++; if ({mem_result, mem_rd, mem_reg_write, mem_mem_read} !== {64'h22, 5'd2, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL b2b_second got %h %0d exp 22 2", mem_result, mem_rd); end
    idle();
  endtask

  task automatic test_async_reset();
    idle(); ex_valid = 1; ex_result = 64'hDEAD; ex_reg_write = 1; ex_set_flags = 1; ex_negative = 1; ex_carry_out = 1;
    step();
    n_cmp++; if ({mem_valid, flags_nzcv} !== {1'b1, 4'b1010}) begin
      n_bad++; $display("FAIL pre_reset got %b %b exp 1 1010", mem_valid, flags_nzcv); end
    #2 reset_n = 0;
    #1;
    n_cmp++; if ({mem_valid, mem_result, mem_reg_write, flags_nzcv} !== '0) begin
      n_bad++; $display("FAIL async_reset got %b %h %b %b exp 0", mem_valid, mem_result, mem_reg_write, flags_nzcv); end
    idle(); step();
    reset_n = 1;
    step();
  endtask

`ifdef EXEC_PERF_CNT_EN
  task automatic test_perf();
    n_cmp++; if ({perf_br_resolved, perf_br_taken} !== 64'd0) begin
      n_bad++; $display("FAIL perf_reset got %0d %0d exp 0 0", perf_br_resolved, perf_br_taken); end
    idle(); ex_valid = 1;
    ex_br_kind = 2'b01; ex_cond = 4'h0; step();
    ex_cond = 4'hE; step();
    ex_br_kind = 2'b10; ex_zero = 1; step();
    ex_br_kind = 2'b11; step();
    ex_br_kind = 2'b01; ex_cond = 4'h4; step();
    ex_cond = 4'hE; stall = 1; step();
    stall = 0; flush = 1; step();
    flush = 0; ex_br_kind = 2'b00; step();
    idle();
    n_cmp++; if (perf_br_resolved !== 32'd5) begin n_bad++; $display("FAIL perf_resolved got %0d exp 5", perf_br_resolved); end
    n_cmp++; if (perf_br_taken !== 32'd2) begin n_bad++; $display("FAIL perf_taken got %0d exp 2", perf_br_taken); end
  endtask
`endif

  initial begin
    test_reset();
    test_subs_eq();
    test_cond_lt_ge();
    test_cbz_cbnz();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
`ifdef EXEC_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
